// File: rtl/pipelined_full_adder.sv
`default_nettype none
// =============================================================================
// Module   : pipelined_full_adder
// Purpose  : N-bit add/subtract split into S ripple segments, one register
//            stage per segment, valid/ready handshake with full back-pressure.
// Revision : 1.0
// =============================================================================
module pipelined_full_adder #(
    parameter int N = 64,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / S;

    logic [N-1:0] w_b_eff;
    logic         w_c0;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = cin ^ sub;

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            logic                 v_q;
            logic                 c_q;
            logic [(k+1)*W-1:0]   sum_q;

            logic                 w_src_v;
            logic                 w_src_c;
            logic [W-1:0]         w_src_a;
            logic [W-1:0]         w_src_b;
            logic [W-1:0]         w_seg;
            logic                 w_cout;
            logic [(k+1)*W-1:0]   w_sum_d;
            logic                 w_load;
            logic                 w_adv;

            if (k == 0) begin : g_src_in
                assign w_src_v = in_valid;
                assign w_src_c = w_c0;
                assign w_src_a = a[W-1:0];
                assign w_src_b = w_b_eff[W-1:0];
                assign w_sum_d = w_seg;
            end else begin : g_src_prev
                assign w_src_v = g_stage[k-1].v_q;
                assign w_src_c = g_stage[k-1].c_q;
                assign w_src_a = g_stage[k-1].g_ops.a_q[W-1:0];
                assign w_src_b = g_stage[k-1].g_ops.b_q[W-1:0];
                assign w_sum_d = {w_seg, g_stage[k-1].sum_q};
            end

            always_comb begin : p_segment
                logic c;
                c     = w_src_c;
                w_seg = '0;
                for (int i = 0; i < W; i++) begin
                    w_seg[i] = w_src_a[i] ^ w_src_b[i] ^ c;
                    c        = (w_src_a[i] & w_src_b[i]) | (c & (w_src_a[i] ^ w_src_b[i]));
                end
                w_cout = c;
            end

            // A stage frees up when its beat moves on; this ripples back to in_ready.
            if (k == S-1) begin : g_adv_out
                assign w_adv = v_q & out_ready;
            end else begin : g_adv_mid
                assign w_adv = v_q & g_stage[k+1].w_load;
            end
            assign w_load = ~v_q | w_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                end else if (w_load) begin
                    v_q <= w_src_v;
                    if (w_src_v) begin
                        c_q   <= w_cout;
                        sum_q <= w_sum_d;
                    end
                end
            end

            if (k < S-1) begin : g_ops
                // Only the still-unprocessed upper operand bits travel onward.
                localparam int R = N - (k+1)*W;
                logic [R-1:0] a_q;
                logic [R-1:0] b_q;
                logic [R-1:0] w_a_d;
                logic [R-1:0] w_b_d;

                if (k == 0) begin : g_first
                    assign w_a_d = a[N-1:W];
                    assign w_b_d = w_b_eff[N-1:W];
                end else begin : g_next
                    assign w_a_d = g_stage[k-1].g_ops.a_q[N-k*W-1:W];
                    assign w_b_d = g_stage[k-1].g_ops.b_q[N-k*W-1:W];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (w_load && w_src_v) begin
                        a_q <= w_a_d;
                        b_q <= w_b_d;
                    end
                end
            end else begin : g_last
                logic ovf_q;

                // Carry into the MSB is recovered from the MSB sum bit itself.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (w_load && w_src_v) begin
                        ovf_q <= w_cout ^ (w_src_a[W-1] ^ w_src_b[W-1] ^ w_seg[W-1]);
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = g_stage[0].w_load;
    assign out_valid = g_stage[S-1].v_q;
    assign s         = g_stage[S-1].sum_q;
    assign cout      = g_stage[S-1].c_q;
    assign ovf       = g_stage[S-1].g_last.ovf_q;

endmodule
`default_nettype wire
